sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences every access to the external 1Mx16 SRAM and shares it between two requesters: the SLC-3 CPU memory port (MAR/MDR path) and a program-loader port used to preload SRAM.
- Sits between the requesters and the SRAM tristate interface.
- Produces the SRAM strobes with a fixed setup/access/hold schedule.
- Arbitrates simultaneous requests round-robin and completes each transfer with a one-cycle ack.

Parameters:
WAIT_CYCLES, 2, number of cycles OE or WE is held low per access (legal range 1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, level
cpu_we  in  1  1=write, 0=read
cpu_addr  in  16  CPU word address
cpu_wdata  in  16  CPU write data
cpu_rdata  out  16  CPU read data, registered
cpu_ack  out  1  one-cycle completion pulse to CPU
ldr_req  in  1  loader access request, level
ldr_we  in  1  1=write, 0=read
ldr_addr  in  16  loader word address
ldr_wdata  in  16  loader write data
ldr_rdata  out  16  loader read data, registered
ldr_ack  out  1  one-cycle completion pulse to loader
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low
ADDR  out  20  SRAM address, {4'h0, granted addr}
Data_to_SRAM  out  16  write data to tristate
Data_from_SRAM  in  16  read data from tristate
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: Mem_* = 1 (all inactive), ADDR = 0, Data_to_SRAM = 0, cpu_rdata = ldr_rdata = 0, acks = 0, busy = 0, state = IDLE, last_grant = LDR (CPU wins the first tie).
- All outputs are registered.
- Reset asserted mid-transfer: immediately returns every output to its reset value and the state to IDLE. No ack is issued. The aborted access is not resumed.
- FSM states and transitions:
  - IDLE
    - No req: stay in IDLE.
    - One req: grant that requester.
    - Both reqs: grant the requester that is not last_grant.
    - On grant: latch we/addr/wdata of the winner, update last_grant, go to SETUP.
  - SETUP (1 cycle)
    - CE/UB/LB = 0, OE = WE = 1.
    - ADDR valid; Data_to_SRAM valid for writes.
  - ACCESS (WAIT_CYCLES cycles, down-counter)
    - CE/UB/LB = 0.
    - Read: OE = 0. Write: WE = 0.
    - Read data is captured from Data_from_SRAM into the granted requester's rdata at the edge that ends the last ACCESS cycle.
    - The other requester's rdata is unchanged.
  - DONE (1 cycle)
    - OE = WE = 1; CE/UB/LB stay 0; ADDR and Data_to_SRAM held (hold time).
    - Granted ack = 1. Go to IDLE.
  - In IDLE, CE/UB/LB = 1 and ADDR/Data_to_SRAM keep their last value.
- Latency: req sampled high at edge t (in IDLE) -> ack high in cycle t+2+WAIT_CYCLES. Minimum request-to-request spacing is 3+WAIT_CYCLES cycles.
- Handshake:
  - Requester holds req high until it samples ack = 1, then deasserts req from that same edge.
  - A req still high in IDLE after an ack starts a new transfer.
  - Inputs are latched at grant, so they may change after grant.
  - req dropped after grant: the transfer completes and ack is still pulsed.
  - req raised in a non-IDLE state waits for IDLE. It is never lost while held.
- Fairness: with both reqs held continuously, grants strictly alternate CPU, LDR, CPU, ...
- WE and OE are never low in the same cycle. WE never falls in the cycle ADDR changes.

Test Plan:
1. CPU read, WAIT_CYCLES=2: cpu_req=1, cpu_we=0, cpu_addr=0x0012, Data_from_SRAM=0xBEEF; req first sampled at edge 0.
   - ADDR=0x00012 from cycle 1; OE low cycles 2-3; cpu_ack high only in cycle 4; cpu_rdata=0xBEEF; ldr_rdata still 0.
2. Loader write: ldr_we=1, ldr_addr=0xFFFF, ldr_wdata=0x1234.
   - ADDR=0x0FFFF and Data_to_SRAM=0x1234 from SETUP through DONE; WE low exactly 2 cycles; OE never low; ldr_ack single pulse.
3. Simultaneous requests out of reset: both req=1 at the same edge.
   - CPU granted first; loader acked 5 cycles after the CPU ack; with both held, grant order is C, L, C, L.
4. Early drop: cpu_req pulsed high for one IDLE cycle only.
   - Full access occurs; cpu_ack pulses at cycle 4; FSM returns to IDLE and busy falls.
5. Reset mid-ACCESS: Reset=0 during the first write ACCESS cycle.
   - WE/CE go high asynchronously; ADDR=0; no ack; after release, a new read completes normally.
6. WAIT_CYCLES=1 build: read latency 3 cycles, OE low 1 cycle, rdata correct.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundle of requester handshakes and SRAM strobes/buses for sram_arbiter.
// slave  : the arbiter's view (requests and SRAM read data in; everything else out)
// master : the environment's view (CPU, loader and the SRAM tristate side)
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;

  logic        ldr_req;
  logic        ldr_we;
  logic [15:0] ldr_addr;
  logic [15:0] ldr_wdata;
  logic [15:0] ldr_rdata;
  logic        ldr_ack;

  logic        Mem_CE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  Data_from_SRAM,
    output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
    output ADDR, Data_to_SRAM, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output Data_from_SRAM,
    input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
    input  ADDR, Data_to_SRAM, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// SRAM access sequencer shared by the CPU memory port and the program loader.
// Every access runs SETUP -> ACCESS (WAIT_CYCLES) -> DONE, with a one-cycle ack.
// Simultaneous requests are granted round-robin; the CPU wins the first tie.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | chip deselected, ADDR/Data_to_SRAM hold last value, arbitrating
// SETUP  | CE/UB/LB low, ADDR (and write data) driven, OE/WE high
// ACCESS | OE (read) or WE (write) low for WAIT_CYCLES cycles, down-counter
// DONE   | OE/WE high, CE low, bus held for hold time, ack to the winner
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input logic           Clk,
  input logic           Reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // ACCESS timer counts down to zero, so it is loaded with one less than the width
  localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  // r_gnt_cpu is both the owner of the current transfer and last_grant
  logic        r_gnt_cpu;
  logic        r_we;

  logic        w_grant;
  logic        w_win_cpu;
  logic        w_sel_we;
  logic [15:0] w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic        w_capture;

  logic        r_ce;
  logic        r_oe_n;
  logic        r_we_n;
  logic [19:0] r_addr;
  logic [15:0] r_dout;
  logic        r_busy;
  logic        r_cpu_ack;
  logic        r_ldr_ack;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_ldr_rdata;

  // state register and ACCESS down-counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next state, round-robin winner selection and timer control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    // on a tie the CPU wins only if the loader had the previous grant
    w_win_cpu   = bus.cpu_req && (!bus.ldr_req || !r_gnt_cpu);
    w_sel_we    = w_win_cpu ? bus.cpu_we    : bus.ldr_we;
    w_sel_addr  = w_win_cpu ? bus.cpu_addr  : bus.ldr_addr;
    w_sel_wdata = w_win_cpu ? bus.cpu_wdata : bus.ldr_wdata;

    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_cnt_nxt   = LP_CNT_LOAD;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_capture   = !r_we;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // latch the winner's request fields at grant
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_gnt_cpu <= 1'b0;
      r_we      <= 1'b0;
    end else if (w_grant) begin
      r_gnt_cpu <= w_win_cpu;
      r_we      <= w_sel_we;
    end
  end

  // SRAM strobes, bus and busy are registered from the next state so they
  // change cleanly on the edge that enters each phase
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ce   <= 1'b1;
      r_oe_n <= 1'b1;
      r_we_n <= 1'b1;
      r_addr <= '0;
      r_dout <= '0;
      r_busy <= 1'b0;
    end else begin
      r_ce   <= (w_state_nxt == ST_IDLE);
      r_oe_n <= !((w_state_nxt == ST_ACCESS) && !r_we);
      r_we_n <= !((w_state_nxt == ST_ACCESS) && r_we);
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_grant) begin
        r_addr <= {4'h0, w_sel_addr};
        if (w_sel_we) begin
          r_dout <= w_sel_wdata;
        end
      end
    end
  end

  // completion pulses and read-data capture for the granted requester
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      r_cpu_ack <= (w_state_nxt == ST_DONE) && r_gnt_cpu;
      r_ldr_ack <= (w_state_nxt == ST_DONE) && !r_gnt_cpu;
      if (w_capture && r_gnt_cpu) begin
        r_cpu_rdata <= bus.Data_from_SRAM;
      end
      if (w_capture && !r_gnt_cpu) begin
        r_ldr_rdata <= bus.Data_from_SRAM;
      end
    end
  end

  assign bus.Mem_CE       = r_ce;
  assign bus.Mem_UB       = r_ce;
  assign bus.Mem_LB       = r_ce;
  assign bus.Mem_OE       = r_oe_n;
  assign bus.Mem_WE       = r_we_n;
  assign bus.ADDR         = r_addr;
  assign bus.Data_to_SRAM = r_dout;
  assign bus.busy         = r_busy;
  assign bus.cpu_ack      = r_cpu_ack;
  assign bus.ldr_ack      = r_ldr_ack;
  assign bus.cpu_rdata    = r_cpu_rdata;
  assign bus.ldr_rdata    = r_ldr_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, directed corner sequences, and a
// randomized two-requester run against a transaction-level reference model.
module tb_sram_arbiter;
  localparam int W0 = 2;
  localparam int W1 = 1;

  logic Clk = 1'b0;
  logic rst0;
  logic rst1;
  always #5 Clk = ~Clk;

  sram_arbiter_if if0 ();
  sram_arbiter_if if1 ();

  sram_arbiter #(.WAIT_CYCLES(W0)) u_dut0 (.Clk(Clk), .Reset(rst0), .bus(if0.slave));
  sram_arbiter #(.WAIT_CYCLES(W1)) u_dut1 (.Clk(Clk), .Reset(rst1), .bus(if1.slave));

  // SRAM model for the WAIT_CYCLES=2 instance; bus floats to DEAD when OE is high
  logic [15:0] mem0 [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [15:0] ld_val;
  always @(posedge Clk) begin
    if (ld_en) mem0[ld_idx] <= ld_val;
    else if (!if0.Mem_WE && !if0.Mem_CE) mem0[if0.ADDR[5:0]] <= if0.Data_to_SRAM;
  end
  assign if0.Data_from_SRAM = !if0.Mem_OE ? mem0[if0.ADDR[5:0]] : 16'hDEAD;
  assign if1.Data_from_SRAM = !if1.Mem_OE ? (16'h5A5A ^ {10'h0, if1.ADDR[5:0]}) : 16'hDEAD;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_ldr;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          pre_en;
    logic [15:0] pre_val;
    logic [19:0] exp_addr;
    logic [15:0] exp_rd_cpu;
    logic [15:0] exp_rd_ldr;
    int          exp_lat;
    int          exp_oe_lo;
    int          exp_we_lo;
  } vec_t;

  vec_t vecs [6];

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic mem_load(input logic [5:0] idx, input logic [15:0] val);
    ld_en  = 1'b1;
    ld_idx = idx;
    ld_val = val;
    cyc();
    ld_en  = 1'b0;
  endtask

  task automatic clr_in0();
    if0.cpu_req = 0; if0.cpu_we = 0; if0.cpu_addr = 0; if0.cpu_wdata = 0;
    if0.ldr_req = 0; if0.ldr_we = 0; if0.ldr_addr = 0; if0.ldr_wdata = 0;
  endtask

  task automatic pulse_reset0();
    clr_in0();
    rst0 = 1'b0;
    cyc();
    cyc();
    rst0 = 1'b1;
    cyc();
  endtask

  // one isolated transfer on the W0 instance, started at a negedge
  task automatic run_vec(input vec_t v, input string tag);
    int ack_cyc, ack_cnt, oth_cnt, oe_lo, we_lo, both_lo, addr_bad, dout_bad, ce_bad;
    logic a, o;
    ack_cyc = 0; ack_cnt = 0; oth_cnt = 0; oe_lo = 0; we_lo = 0;
    both_lo = 0; addr_bad = 0; dout_bad = 0; ce_bad = 0;
    if (v.pre_en) mem_load(v.addr[5:0], v.pre_val);
    if (v.is_ldr) begin
      if0.ldr_req = 1; if0.ldr_we = v.we; if0.ldr_addr = v.addr; if0.ldr_wdata = v.wdata;
    end else begin
      if0.cpu_req = 1; if0.cpu_we = v.we; if0.cpu_addr = v.addr; if0.cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      a = v.is_ldr ? if0.ldr_ack : if0.cpu_ack;
      o = v.is_ldr ? if0.cpu_ack : if0.ldr_ack;
      if (a) begin
        ack_cnt++;
        if (ack_cyc == 0) ack_cyc = k;
        if0.cpu_req = 0;
        if0.ldr_req = 0;
      end
      if (o) oth_cnt++;
      if (!if0.Mem_OE) oe_lo++;
      if (!if0.Mem_WE) we_lo++;
      if (!if0.Mem_OE && !if0.Mem_WE) both_lo++;
      if (if0.busy && if0.ADDR !== v.exp_addr) addr_bad++;
      if (if0.busy && v.we && if0.Data_to_SRAM !== v.wdata) dout_bad++;
      if (if0.Mem_CE !== !if0.busy) ce_bad++;
    end
    chk({tag, "_ack_cycle"}, ack_cyc, v.exp_lat);
    chk({tag, "_ack_count"}, ack_cnt, 1);
    chk({tag, "_other_ack"}, oth_cnt, 0);
    chk({tag, "_oe_low_cycles"}, oe_lo, v.exp_oe_lo);
    chk({tag, "_we_low_cycles"}, we_lo, v.exp_we_lo);
    chk({tag, "_oe_we_overlap"}, both_lo, 0);
    chk({tag, "_addr_bad_cycles"}, addr_bad, 0);
    chk({tag, "_wdata_bad_cycles"}, dout_bad, 0);
    chk({tag, "_ce_vs_busy"}, ce_bad, 0);
    chk({tag, "_cpu_rdata"}, if0.cpu_rdata, v.exp_rd_cpu);
    chk({tag, "_ldr_rdata"}, if0.ldr_rdata, v.exp_rd_ldr);
    chk({tag, "_busy_end"}, if0.busy, 0);
  endtask

  // randomized-run reference model state
  logic [15:0] ref_mem [64];

  task automatic run_random(input int n_cyc);
    int e, m_free, g_edge, d;
    bit m_act, g_cpu, g_we, m_last_cpu, in_x, acc, ack_now;
    logic [15:0] g_addr, g_wdata, g_exp_rd, exp_rd_c, exp_rd_l;
    e = 0; m_free = 0; g_edge = 0; m_act = 0; g_cpu = 0; g_we = 0; m_last_cpu = 0;
    g_addr = 0; g_wdata = 0; g_exp_rd = 0; exp_rd_c = 0; exp_rd_l = 0;
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge Clk);
      e++;
      if (e >= m_free && (if0.cpu_req || if0.ldr_req)) begin
        g_cpu      = if0.cpu_req && !(if0.ldr_req && m_last_cpu);
        g_we       = g_cpu ? if0.cpu_we : if0.ldr_we;
        g_addr     = g_cpu ? if0.cpu_addr : if0.ldr_addr;
        g_wdata    = g_cpu ? if0.cpu_wdata : if0.ldr_wdata;
        m_last_cpu = g_cpu;
        g_edge     = e;
        m_free     = e + W0 + 3;
        m_act      = 1;
        if (g_we) ref_mem[g_addr[5:0]] = g_wdata;
        else g_exp_rd = ref_mem[g_addr[5:0]];
      end
      @(negedge Clk);
      d       = e - g_edge;
      in_x    = m_act && d <= W0 + 1;
      acc     = in_x && d >= 1 && d <= W0;
      ack_now = in_x && d == W0 + 1;
      if (ack_now && !g_we) begin
        if (g_cpu) exp_rd_c = g_exp_rd;
        else exp_rd_l = g_exp_rd;
      end
      chk("rnd_busy", if0.busy, in_x);
      chk("rnd_ce_ub_lb", {if0.Mem_CE, if0.Mem_UB, if0.Mem_LB}, {3{!in_x}});
      chk("rnd_oe", if0.Mem_OE, !(acc && !g_we));
      chk("rnd_we", if0.Mem_WE, !(acc && g_we));
      chk("rnd_cpu_ack", if0.cpu_ack, ack_now && g_cpu);
      chk("rnd_ldr_ack", if0.ldr_ack, ack_now && !g_cpu);
      chk("rnd_cpu_rdata", if0.cpu_rdata, exp_rd_c);
      chk("rnd_ldr_rdata", if0.ldr_rdata, exp_rd_l);
      if (in_x) chk("rnd_addr", if0.ADDR, {4'h0, g_addr});
      if (in_x && g_we) chk("rnd_wdata", if0.Data_to_SRAM, g_wdata);
      if (ack_now) m_act = 0;
      // requester behaviour: on ack either chain a new request or drop
      if (ack_now && g_cpu) begin
        if ($urandom_range(1, 0) == 1) begin
          if0.cpu_we = 1'($urandom); if0.cpu_addr = 16'($urandom); if0.cpu_wdata = 16'($urandom);
        end else if0.cpu_req = 0;
      end
      if (ack_now && !g_cpu) begin
        if ($urandom_range(1, 0) == 1) begin
          if0.ldr_we = 1'($urandom); if0.ldr_addr = 16'($urandom); if0.ldr_wdata = 16'($urandom);
        end else if0.ldr_req = 0;
      end
      // fields are latched at grant: scramble them, sometimes drop req early
      if (m_act && e == g_edge) begin
        if (g_cpu) begin
          if0.cpu_we = 1'($urandom); if0.cpu_addr = 16'($urandom); if0.cpu_wdata = 16'($urandom);
          if ($urandom_range(3, 0) == 0) if0.cpu_req = 0;
        end else begin
          if0.ldr_we = 1'($urandom); if0.ldr_addr = 16'($urandom); if0.ldr_wdata = 16'($urandom);
          if ($urandom_range(3, 0) == 0) if0.ldr_req = 0;
        end
      end
      if (!if0.cpu_req && $urandom_range(3, 0) == 0) begin
        if0.cpu_req = 1; if0.cpu_we = 1'($urandom);
        if0.cpu_addr = 16'($urandom); if0.cpu_wdata = 16'($urandom);
      end
      if (!if0.ldr_req && $urandom_range(3, 0) == 0) begin
        if0.ldr_req = 1; if0.ldr_we = 1'($urandom);
        if0.ldr_addr = 16'($urandom); if0.ldr_wdata = 16'($urandom);
      end
    end
    if0.cpu_req = 0;
    if0.ldr_req = 0;
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_bad = 0;
    ld_en = 0; ld_idx = 0; ld_val = 0;
    rst0 = 0;
    rst1 = 0;
    clr_in0();
    if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = 0; if1.cpu_wdata = 0;
    if1.ldr_req = 0; if1.ldr_we = 0; if1.ldr_addr = 0; if1.ldr_wdata = 0;

    //            ldr we  addr     wdata    pre pre_val  exp_addr   rd_cpu   rd_ldr lat oe we
    vecs[0] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'hBEEF, 20'h00012, 16'hBEEF, 16'h0000, 4, 2, 0};
    vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 20'h0FFFF, 16'hBEEF, 16'h0000, 4, 0, 2};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 20'h0FFFF, 16'hBEEF, 16'h1234, 4, 2, 0};
    vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'hA5C3, 1'b0, 16'h0000, 20'h00040, 16'hBEEF, 16'h1234, 4, 0, 2};
    vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 20'h00040, 16'hA5C3, 16'h1234, 4, 2, 0};
    vecs[5] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 16'h0000, 20'h00012, 16'hA5C3, 16'hBEEF, 4, 2, 0};

    repeat (3) @(negedge Clk);
    chk("rst_ce", if0.Mem_CE, 1);
    chk("rst_ub_lb", {if0.Mem_UB, if0.Mem_LB}, 2'b11);
    chk("rst_oe", if0.Mem_OE, 1);
    chk("rst_we", if0.Mem_WE, 1);
    chk("rst_addr", if0.ADDR, 0);
    chk("rst_dout", if0.Data_to_SRAM, 0);
    chk("rst_rdata", {if0.cpu_rdata, if0.ldr_rdata}, 0);
    chk("rst_acks", {if0.cpu_ack, if0.ldr_ack}, 0);
    chk("rst_busy", if0.busy, 0);
    rst0 = 1;
    rst1 = 1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // simultaneous requests out of reset, both held: C, L, C, L
    pulse_reset0();
    if0.cpu_req = 1; if0.cpu_we = 0; if0.cpu_addr = 16'h0001;
    if0.ldr_req = 1; if0.ldr_we = 0; if0.ldr_addr = 16'h0002;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("fair_cpu_ack_c%0d", k), if0.cpu_ack, (k == 4 || k == 14));
      chk($sformatf("fair_ldr_ack_c%0d", k), if0.ldr_ack, (k == 9 || k == 19));
    end
    if0.cpu_req = 0;
    if0.ldr_req = 0;
    repeat (6) cyc();
    chk("fair_idle", if0.busy, 0);

    // one-cycle request pulse still completes
    if0.cpu_req = 1; if0.cpu_we = 0; if0.cpu_addr = 16'h0012;
    @(posedge Clk);
    @(negedge Clk);
    if0.cpu_req = 0;
    for (int k = 2; k <= 7; k++) begin
      cyc();
      chk($sformatf("drop_ack_c%0d", k), if0.cpu_ack, (k == 4));
      chk($sformatf("drop_busy_c%0d", k), if0.busy, (k <= 4));
    end
    chk("drop_rdata", if0.cpu_rdata, 16'hBEEF);

    // reset during the first write ACCESS cycle
    if0.cpu_req = 1; if0.cpu_we = 1; if0.cpu_addr = 16'h0021; if0.cpu_wdata = 16'h7777;
    cyc();
    chk("rstmid_setup_we", if0.Mem_WE, 1);
    cyc();
    chk("rstmid_access_we", if0.Mem_WE, 0);
    rst0 = 0;
    if0.cpu_req = 0;
    #1;
    chk("rstmid_we", if0.Mem_WE, 1);
    chk("rstmid_ce", if0.Mem_CE, 1);
    chk("rstmid_addr", if0.ADDR, 0);
    chk("rstmid_dout", if0.Data_to_SRAM, 0);
    chk("rstmid_busy", if0.busy, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rstmid_no_ack", if0.cpu_ack, 0);
    end
    rst0 = 1;
    cyc();
    chk("rstmid_stays_idle", if0.busy, 0);
    chk("rstmid_no_ack_after", if0.cpu_ack, 0);
    v = '{1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, 16'h0000, 20'h00012, 16'hBEEF, 16'h0000, 4, 2, 0};
    run_vec(v, "rstmid_read");

    // WAIT_CYCLES=1 instance
    if1.cpu_req = 1; if1.cpu_we = 0; if1.cpu_addr = 16'h0005;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("w1_ack_c%0d", k), if1.cpu_ack, (k == 3));
      chk($sformatf("w1_oe_c%0d", k), if1.Mem_OE, (k != 2));
      if (if1.cpu_ack) if1.cpu_req = 0;
    end
    chk("w1_rdata", if1.cpu_rdata, 16'h5A5F);
    chk("w1_ldr_rdata", if1.ldr_rdata, 16'h0000);

    // randomized run against the reference model
    pulse_reset0();
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 16'($urandom);
      mem_load(6'(i), ref_mem[i]);
    end
    run_random(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
